cla_pipe_adder: RTL
===================

Name: cla_pipe_adder

Overview:
- Parametrised, 2-stage pipelined carry-lookahead adder built from GROUP-bit lookahead groups.
- A second-level lookahead spans the groups.
- Valid/ready handshake on both sides; sits between operand staging logic and the ALU result bus.
- Exposes every group-boundary carry (the generalised c1..cN) alongside the sum and carry-out.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per first-level lookahead group; legal values 2..8.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/cin valid
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (c0)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  a+b+cin modulo 2^WIDTH
- carries  out  WIDTH/GROUP  carry into bit (k+1)*GROUP for group k; MSB equals cout
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow, only with CLA_OVF_EN

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: all stage valids 0, so out_valid=0; sum, carries, cout and ovf all 0; in_ready=1 after reset release.
- Stage 1 (S1), on accept:
  - Registers per-bit g=a&b and p=a|b, plus the half sum a^b, cin and valid.
  - Computes each group's G and P: G = g_top | p_top&g_top-1 | ... ; P = AND of the group's bit p values.
- Stage 2 (S2):
  - Second-level lookahead: C[k+1] = G[k] | P[k]&C[k], with C[0]=cin, flattened (no ripple across groups).
  - Intra-group carries use the same flattened form.
  - sum = half_sum ^ carry_vector.
  - Registers sum, carries, cout and valid.
- Latency: exactly 2 clk edges from in_valid&&in_ready to out_valid=1, with no stalls. Throughput: 1 result/cycle.
- Advance rules:
  - S2 loads when !s2_valid or out_ready.
  - S1 loads when !s1_valid or S2 loads.
  - in_ready = !s1_valid | !s2_valid | out_ready. Combinational from out_ready; no other comb paths from inputs to outputs.
- Stall: with out_valid=1 and out_ready=0, sum, carries and cout hold bit-stable; a held result is never overwritten.
- Bubbles: an S1 bubble (s1_valid=0) may be squeezed out while S2 is stalled; at most 2 transactions are in flight.
- in_valid while in_ready=0: ignored; the source must hold its operands.
- Data registers load only on accept; stale data persists while valid=0.
- Reset mid-operation: in-flight results are discarded immediately (asynchronous), with no partial output.
- Wrap-around: sum is mod 2^WIDTH; cout carries the lost bit.

Optional Feature:
- Macro: CLA_OVF_EN.
- Defined:
  - ovf port present.
  - ovf = C[WIDTH] ^ C[WIDTH-1] (carry into MSB xor carry out), registered in S2 and held under stall like sum.
  - Reset value 0.
- Undefined: ovf port and its logic absent; all other behaviour identical.

Decomposition:
- Package cla_pkg:
  - localparam function ngroups(WIDTH, GROUP).
  - typedef struct for the S1 pipeline word {half_sum, g, p, cin}.
  - Elaboration-time assertion that WIDTH % GROUP == 0.
- Sub-module cla_group:
  - Combinational, GROUP-bit.
  - Takes g/p/carry-in; produces group G, group P and internal carries.
  - Instantiated ngroups times in S1 (for G/P) and S2 (for carries).

Test Plan:
- Boundary add: a=16'hFFFF, b=16'h0001, cin=0 -> two cycles later sum=16'h0000, cout=1, carries=4'b1111.
- Propagate chain: a=16'hFFFF, b=16'h0000, cin=1 -> sum=0, cout=1; with cin=0 -> sum=16'hFFFF, cout=0, carries=0.
- Backpressure:
  - Stimulus: issue 3 back-to-back transactions with out_ready=0 for 4 cycles.
  - Expect: in_ready=0 after 2 accepted; out sum holds stable; on release, results emerge in order, none dropped or duplicated.
- Reset mid-flight: assert rst_n=0 with both stages valid -> out_valid=0 and sum=0 that same cycle; first post-reset input returns after exactly 2 cycles.
- Overflow (CLA_OVF_EN): a=16'h7FFF, b=16'h0001 -> ovf=1, cout=0; a=16'h8000, b=16'h8000 -> ovf=1, cout=1, sum=0.
- Random:
  - Stimulus: 10k random a/b/cin with random in_valid/out_ready, for WIDTH=16/GROUP=4 and WIDTH=32/GROUP=8.
  - Expect: scoreboard matches a+b+cin and every group carry.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-lookahead adder.
// Holds the per-bit S1 pipeline lane, the group-count helper and the geometry check.
package cla_pkg;

    function automatic int ngroups(input int width, input int group);
        return width / group;
    endfunction

    function automatic bit cfg_ok(input int width, input int group);
        return (group >= 2) && (group <= 8) && (width >= group) && ((width % group) == 0);
    endfunction

    // One lane of the S1 pipeline word; the word is an array of these plus the carry-in.
    typedef struct packed {
        logic half_sum;
        logic g;
        logic p;
    } s1_bit_t;

endpackage

// File: rtl/cla_group.sv
// GROUP-bit first-level lookahead: group generate/propagate and flattened internal carries.
// Purely combinational; no backpressure.
// G/P and carries sit in separate processes so G/P never depends on i_c.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] i_g,
    input  logic [GROUP-1:0] i_p,
    input  logic             i_c,
    output logic             o_g,
    output logic             o_p,
    output logic [GROUP-1:0] o_c
);

    always_comb begin : p_gp
        logic v_prod;
        v_prod = 1'b0;
        o_g    = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            v_prod = i_g[j];
            for (int m = j + 1; m < GROUP; m++) begin
                v_prod = v_prod & i_p[m];
            end
            o_g = o_g | v_prod;
        end
        o_p = &i_p;
    end

    // o_c[i] is the carry into bit i, written as a sum of products (no ripple).
    always_comb begin : p_carry
        logic v_term;
        v_term = 1'b0;
        o_c    = '0;
        for (int i = 0; i < GROUP; i++) begin
            v_term = i_c;
            for (int m = 0; m < i; m++) begin
                v_term = v_term & i_p[m];
            end
            o_c[i] = v_term;
            for (int j = 0; j < i; j++) begin
                v_term = i_g[j];
                for (int m = j + 1; m < i; m++) begin
                    v_term = v_term & i_p[m];
                end
                o_c[i] = o_c[i] | v_term;
            end
        end
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with exposed group carries; CLA_OVF_EN adds ovf.
// Latency 2 clk edges from accept to out_valid, 1 result/cycle.
// Backpressure: out_ready stalls S2 and S1; in_ready = !s1_vld | !s2_vld | out_ready.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       sum,
    output logic [WIDTH/GROUP-1:0] carries,
    output logic                   cout
`ifdef CLA_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int NG = ngroups(WIDTH, GROUP);

    if (!cfg_ok(WIDTH, GROUP)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP and GROUP must be 2..8");
    end

    s1_bit_t [WIDTH-1:0] w_in_word;
    s1_bit_t [WIDTH-1:0] r_s1_dat;
    logic                r_s1_cin;
    logic                r_s1_vld;
    logic                r_s2_vld;
    logic [WIDTH-1:0]    r_sum;
    logic [NG-1:0]       r_carries;
    logic                r_cout;
`ifdef CLA_OVF_EN
    logic                r_ovf;
`endif

    logic                w_s1_load;
    logic                w_s2_load;
    logic [WIDTH-1:0]    w_g;
    logic [WIDTH-1:0]    w_p;
    logic [WIDTH-1:0]    w_hs;
    logic [NG-1:0]       w_grp_g;
    logic [NG-1:0]       w_grp_p;
    logic [NG:0]         w_c_grp;
    logic [WIDTH-1:0]    w_cvec;
    logic [WIDTH-1:0]    w_sum;

    assign w_s2_load = !r_s2_vld || out_ready;
    assign w_s1_load = !r_s1_vld || w_s2_load;
    assign in_ready  = !r_s1_vld || !r_s2_vld || out_ready;

    always_comb begin
        w_in_word = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_in_word[i].half_sum = a[i] ^ b[i];
            w_in_word[i].g        = a[i] & b[i];
            w_in_word[i].p        = a[i] | b[i];
        end
    end

    always_comb begin
        w_g  = '0;
        w_p  = '0;
        w_hs = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_g[i]  = r_s1_dat[i].g;
            w_p[i]  = r_s1_dat[i].p;
            w_hs[i] = r_s1_dat[i].half_sum;
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .i_g (w_g[k*GROUP +: GROUP]),
            .i_p (w_p[k*GROUP +: GROUP]),
            .i_c (w_c_grp[k]),
            .o_g (w_grp_g[k]),
            .o_p (w_grp_p[k]),
            .o_c (w_cvec[k*GROUP +: GROUP])
        );
    end

    // Second-level lookahead: every C[k] built directly from group G/P and cin.
    always_comb begin : p_level2
        logic v_prod;
        logic v_or;
        v_prod     = 1'b0;
        v_or       = 1'b0;
        w_c_grp    = '0;
        w_c_grp[0] = r_s1_cin;
        for (int k = 1; k <= NG; k++) begin
            v_or = r_s1_cin;
            for (int j = 0; j < k; j++) begin
                v_or = v_or & w_grp_p[j];
            end
            for (int j = 0; j < k; j++) begin
                v_prod = w_grp_g[j];
                for (int m = j + 1; m < k; m++) begin
                    v_prod = v_prod & w_grp_p[m];
                end
                v_or = v_or | v_prod;
            end
            w_c_grp[k] = v_or;
        end
    end

    assign w_sum = w_hs ^ w_cvec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_cin <= 1'b0;
            r_s1_dat <= '0;
        end else if (w_s1_load) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_dat <= w_in_word;
                r_s1_cin <= cin;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_sum     <= '0;
            r_carries <= '0;
            r_cout    <= 1'b0;
`ifdef CLA_OVF_EN
            r_ovf     <= 1'b0;
`endif
        end else if (w_s2_load) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_sum     <= w_sum;
                r_carries <= w_c_grp[NG:1];
                r_cout    <= w_c_grp[NG];
`ifdef CLA_OVF_EN
                r_ovf     <= w_c_grp[NG] ^ w_cvec[WIDTH-1];
`endif
            end
        end
    end

    assign out_valid = r_s2_vld;
    assign sum       = r_sum;
    assign carries   = r_carries;
    assign cout      = r_cout;
`ifdef CLA_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule
